mux_share_arb: RTL
==================

Name: mux_share_arb

Overview:
- Two-requester round-robin arbiter that owns the select line of a shared 2:1 mux datapath.
- Requester 0 drives mux input A; requester 1 drives mux input B. The mux output Y is shared.
- The block grants the mux to one requester at a time and drives S0 to match.
- Enforces break-before-make (one idle cycle between grants) and an optional hold limit so neither requester starves the other.

Parameters:
- MAX_HOLD, 8: max consecutive grant cycles per grant; 0 = unlimited.
- HOLD_W, 8: width of the hold counter; MAX_HOLD must be < 2**HOLD_W.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 wants the mux (A path); level, held while using.
- req1  input  1  requester 1 wants the mux (B path); level.
- gnt0  output  1  requester 0 owns the mux; registered.
- gnt1  output  1  requester 1 owns the mux; registered.
- S0  output  1  mux select to datapath; 0 = A, 1 = B; registered.
- busy  output  1  gnt0 | gnt1; registered.
- expire  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high; it takes effect only on a rising clk edge.
- Reset values: gnt0=0, gnt1=0, S0=0, busy=0, expire=0, state=IDLE, hold_cnt=0, last=1 (so req0 wins the first tie).
- States: IDLE, G0, G1. All outputs are registered from state and next-state logic.
- IDLE, no request: stay in IDLE; S0 holds its last value.
- IDLE, req0 only: go to G0; gnt0=1 and S0=0 after the same edge.
- IDLE, req1 only: go to G1; gnt1=1 and S0=1 after the same edge.
- IDLE, both requesting: grant the requester other than `last`. Ties alternate.
- Latency: request sampled high at edge k in IDLE → grant visible after edge k, i.e. 1 cycle.
- Gx: hold_cnt increments every cycle the grant is held, starting from 0 at grant.
- Gx → IDLE when reqx is sampled low (voluntary release). On that edge: gntx=0, last=x, hold_cnt=0, expire=0.
- Gx → IDLE when MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1 (forced release, grant lasted exactly MAX_HOLD cycles). On that edge: gntx=0, last=x, hold_cnt=0, expire=1 for one cycle.
- Voluntary and forced release on the same edge: the release is treated as voluntary; expire=0.
- Break-before-make: at least one IDLE cycle between any two grants. gnt0 and gnt1 are never both 1. S0 changes only on an IDLE→Gx edge, never while busy=1.
- Re-grant after forced release: if the other requester is not requesting, the same requester is re-granted after the one IDLE cycle.
- Requests arriving while in Gx are ignored until the next IDLE cycle. There is no preemption except MAX_HOLD.
- MAX_HOLD=1: every grant lasts 1 cycle with expire asserted. Alternates under contention.
- MAX_HOLD=0: hold_cnt saturates at all-ones and never forces release.
- Reset mid-grant: the next edge with rst=1 forces all reset values, S0=0 included, regardless of state.
- Invariant: busy == gnt0|gnt1 at every cycle.

Optional Feature:
- Macro: MUX_SHARE_ARB_STATS_EN.
- Defined: adds outputs gnt_cnt0 and gnt_cnt1 (16 bits each). Each increments by 1 on every IDLE→Gx edge for its requester and saturates at 16'hFFFF. Both reset to 0 via rst.
- Undefined: the counters and ports are absent. All other behaviour is unchanged.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req0=req1=0 → gnt0=gnt1=0, S0=0, busy=0, expire=0 on every cycle.
- Single requester, MAX_HOLD=4: req1=1 for 2 cycles then 0 → gnt1=1 and S0=1 one cycle after req1 rises. gnt1 drops on the edge req1 is sampled low. expire stays 0. S0 stays 1 in IDLE.
- Contention, MAX_HOLD=4: req0=req1=1 held → grant sequence G0 (4 cycles), IDLE, G1 (4 cycles), IDLE, G0, and so on. expire pulses at each release. S0 toggles only at grant starts, never with busy=1.
- Hog, MAX_HOLD=4: req0=1 held, req1=0 → gnt0 high for 4 cycles, 1 IDLE cycle, re-grant. expire pulses once per 5-cycle period.
- Reset mid-grant: in G1 with hold_cnt=2, assert rst for 1 cycle → next cycle gnt1=0, S0=0, busy=0. With both requesting afterwards, gnt0 wins (last=1).
- Stats (MUX_SHARE_ARB_STATS_EN defined): 3 grants to req0 and 2 grants to req1 → gnt_cnt0=3, gnt_cnt1=2. After rst, both read 0.

Source files
------------

// File: rtl/mux_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : mux_share_arb
// Summary  : Two-requester round-robin arbiter driving the select of a shared
//            2:1 mux, with break-before-make and an optional hold limit.
//            Optional grant statistics enabled by MUX_SHARE_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mux_share_arb #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        S0,
    output logic        busy,
    output logic        expire
`ifdef MUX_SHARE_ARB_STATS_EN
    ,
    output logic [15:0] gnt_cnt0,
    output logic [15:0] gnt_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    localparam bit                c_hold_en   = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] c_hold_sat  = {HOLD_W{1'b1}};

    state_t              r_state;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                r_last;
    logic                r_gnt0;
    logic                r_gnt1;
    logic                r_s0;
    logic                r_busy;
    logic                r_expire;

    logic                w_pick0;
    logic                w_pick1;
    logic                w_limit;

    // r_last names the previous owner, so a tie goes to the other side.
    assign w_pick0 = (r_state == IDLE) && req0 && (!req1 || r_last);
    assign w_pick1 = (r_state == IDLE) && req1 && !w_pick0;
    assign w_limit = c_hold_en && (r_hold_cnt == c_hold_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_last     <= 1'b1;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_s0       <= 1'b0;
            r_busy     <= 1'b0;
            r_expire   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_expire   <= 1'b0;
                    r_hold_cnt <= '0;
                    if (w_pick0) begin
                        r_state <= G0;
                        r_gnt0  <= 1'b1;
                        r_s0    <= 1'b0;
                        r_busy  <= 1'b1;
                    end else if (w_pick1) begin
                        r_state <= G1;
                        r_gnt1  <= 1'b1;
                        r_s0    <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                G0: begin
                    if (!req0 || w_limit) begin
                        // A dropped request wins over the limit: no expire.
                        r_state    <= IDLE;
                        r_gnt0     <= 1'b0;
                        r_busy     <= 1'b0;
                        r_last     <= 1'b0;
                        r_hold_cnt <= '0;
                        r_expire   <= req0;
                    end else if (r_hold_cnt != c_hold_sat) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                G1: begin
                    if (!req1 || w_limit) begin
                        r_state    <= IDLE;
                        r_gnt1     <= 1'b0;
                        r_busy     <= 1'b0;
                        r_last     <= 1'b1;
                        r_hold_cnt <= '0;
                        r_expire   <= req1;
                    end else if (r_hold_cnt != c_hold_sat) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_gnt0     <= 1'b0;
                    r_gnt1     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_expire   <= 1'b0;
                    r_hold_cnt <= '0;
                end
            endcase
        end
    end

    assign gnt0   = r_gnt0;
    assign gnt1   = r_gnt1;
    assign S0     = r_s0;
    assign busy   = r_busy;
    assign expire = r_expire;

`ifdef MUX_SHARE_ARB_STATS_EN
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_pick0 && (r_cnt0 != 16'hFFFF)) r_cnt0 <= r_cnt0 + 16'd1;
            if (w_pick1 && (r_cnt1 != 16'hFFFF)) r_cnt1 <= r_cnt1 + 16'd1;
        end
    end

    assign gnt_cnt0 = r_cnt0;
    assign gnt_cnt1 = r_cnt1;
`endif

endmodule
`default_nettype wire
